// File: rtl/mano_cpu_param.sv
`timescale 1ns/1ps
// Parametrised Mano-style accumulator computer: fetch/execute sequencer, prioritised vectored
// interrupts with hardware return address, halt state and a preload port that is live during reset.
module mano_cpu_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int NUM_IRQ    = 2,
    parameter int VEC_BASE   = 16,
    parameter int VEC_STRIDE = 2,
    parameter int RESET_PC   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic [NUM_IRQ-1:0]  irq,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic [ADDR_W-1:0]   pc,
    output logic [DATA_W-1:0]   ac,
    output logic                e,
    output logic                ien,
    output logic                halted
);

    localparam int K_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int LO_W  = (ADDR_W > 5) ? ADDR_W : 5;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_I0, S_HLT} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  ar, ar_nxt, pc_nxt, ret_pc, ret_nxt;
    logic [2:0]         ir_op, ir_op_nxt;
    logic [LO_W-1:0]    ir_lo, ir_lo_nxt;
    logic [DATA_W-1:0]  dr, dr_nxt, ac_nxt, ac_t, mem_rd, mem_wdata;
    logic               e_nxt, ien_nxt, halted_nxt, mem_we, last;
    logic [K_W-1:0]     irq_k, irq_k_nxt;

    function automatic logic [K_W-1:0] lowest_irq(input logic [NUM_IRQ-1:0] req);
        lowest_irq = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) lowest_irq = K_W'(i);
        end
    endfunction

    function automatic logic [ADDR_W-1:0] vec_addr(input logic [K_W-1:0] k);
        return ADDR_W'(VEC_BASE) + ADDR_W'(int'(k) * VEC_STRIDE);
    endfunction

    assign mem_rd  = mem[ar];
    assign irq_ack = (state == S_I0) ? (NUM_IRQ'(1) << irq_k) : '0;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ar_nxt     = ar;
        ir_op_nxt  = ir_op;
        ir_lo_nxt  = ir_lo;
        dr_nxt     = dr;
        ac_nxt     = ac;
        ac_t       = ac;
        e_nxt      = e;
        ien_nxt    = ien;
        halted_nxt = halted;
        ret_nxt    = ret_pc;
        irq_k_nxt  = irq_k;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        last       = 1'b0;

        case (state)
            S_T0: begin
                ar_nxt    = pc;
                state_nxt = S_T1;
            end
            S_T1: begin
                ir_op_nxt = mem_rd[DATA_W-1 -: 3];
                ir_lo_nxt = mem_rd[LO_W-1:0];
                pc_nxt    = pc + 1'b1;
                state_nxt = S_T2;
            end
            S_T2: begin
                ar_nxt    = ir_lo[ADDR_W-1:0];
                state_nxt = S_T3;
            end
            S_T3: begin
                case (ir_op)
                    3'd0, 3'd1, 3'd2: begin
                        dr_nxt    = mem_rd;
                        state_nxt = S_T4;
                    end
                    3'd3: begin
                        mem_we    = 1'b1;
                        mem_wdata = ac;
                        last      = 1'b1;
                    end
                    3'd4: begin
                        pc_nxt = ar;
                        last   = 1'b1;
                    end
                    3'd5: begin
                        mem_we    = 1'b1;
                        mem_wdata = DATA_W'(pc);
                        ar_nxt    = ar + 1'b1;
                        state_nxt = S_T4;
                    end
                    3'd6: begin
                        if (ir_lo[2]) begin
                            pc_nxt  = ret_pc;
                            ien_nxt = 1'b1;
                        end
                        if (ir_lo[0]) ien_nxt = 1'b1;
                        // IOF is applied last so it overrides ION/RTI in the same word
                        if (ir_lo[1]) ien_nxt = 1'b0;
                        last = 1'b1;
                    end
                    default: begin
                        if (ir_lo[3]) ac_t = '0;
                        if (ir_lo[2]) ac_t = ~ac_t;
                        if (ir_lo[1]) ac_t = ac_t + 1'b1;
                        ac_nxt = ac_t;
                        if (ir_lo[4] && ac == '0) pc_nxt = pc + 1'b1;
                        if (ir_lo[0]) halted_nxt = 1'b1;
                        last = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                case (ir_op)
                    3'd0:    ac_nxt = ac & dr;
                    3'd1:    {e_nxt, ac_nxt} = {1'b0, ac} + {1'b0, dr};
                    3'd2:    ac_nxt = dr;
                    3'd5:    pc_nxt = ar;
                    default: ;
                endcase
                last = 1'b1;
            end
            S_I0: begin
                ret_nxt   = pc;
                pc_nxt    = vec_addr(irq_k);
                ien_nxt   = 1'b0;
                state_nxt = S_T0;
            end
            S_HLT: state_nxt = S_HLT;
            default: state_nxt = S_T0;
        endcase

        // Interrupt check uses the enable as this instruction leaves it, so ION/RTI take effect at once
        if (last) begin
            if (halted_nxt) begin
                state_nxt = S_HLT;
            end else if (ien_nxt && (|irq)) begin
                state_nxt = S_I0;
                irq_k_nxt = lowest_irq(irq);
            end else begin
                state_nxt = S_T0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_T0;
            pc     <= ADDR_W'(RESET_PC);
            ac     <= '0;
            e      <= 1'b0;
            ien    <= 1'b0;
            halted <= 1'b0;
            ret_pc <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ac     <= ac_nxt;
            e      <= e_nxt;
            ien    <= ien_nxt;
            halted <= halted_nxt;
            ret_pc <= ret_nxt;
        end
    end

    always_ff @(posedge clk) begin
        ar    <= ar_nxt;
        ir_op <= ir_op_nxt;
        ir_lo <= ir_lo_nxt;
        dr    <= dr_nxt;
        irq_k <= irq_k_nxt;
    end

    // Preload owns the write port during reset; program stores only when running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (ld_en) mem[ld_addr] <= ld_data;
        end else if (mem_we) begin
            mem[ar] <= mem_wdata;
        end
    end

endmodule
